mem_access_stage: RTL and testbench

// - MEM stage of the 5-stage pipeline, downstream of the EX/MEM pipeline register.
// - Turns the registered load/store controls into a req/ack access on a variable-latency data memory.
// - Stalls upstream while an access is pending, then registers the MEM/WB outputs.
// - Flags misaligned word accesses and memory timeouts with sticky error bits.

---
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store controls into a req/ack access on a
// variable-latency data memory, stalls upstream while the access is pending,
// and registers the MEM/WB outputs. Misaligned word accesses and timeouts
// set sticky error bits.
module mem_access_stage #(
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 5,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] data_2_in,
  input  logic [4:0]  Rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] Read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  Rd_out,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              mis_err_q, mis_err_d;
  logic              to_err_q, to_err_d;

  logic memop, mis, mis_hit;
  logic stall_c, start, done, abort;

  assign memop = MemRead_in | MemWrite_in;
  assign mis   = ALIGN_CHECK & memop & (ALU_result_in[1:0] != 2'b00);

  // FSM next state, access handshake and WB register next values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    mis_hit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mis) begin
          mis_hit = 1'b1;
        end else if (memop) begin
          stall_c = 1'b1;
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // ack wins over the timeout on the final allowed cycle
        if (mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d   = start ? 1'b1 : ((done | abort) ? 1'b0 : req_q);
    we_d    = start ? MemWrite_in   : we_q;
    addr_d  = start ? ALU_result_in : addr_q;
    wdata_d = start ? data_2_in     : wdata_q;

    // while stalled only RegWrite changes (bubble); other WB fields hold
    if (stall_c) begin
      rw_d    = 1'b0;
      m2r_d   = m2r_q;
      alu_d   = alu_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
    end else begin
      rw_d    = RegWrite_in & ~mis_hit & ~abort;
      m2r_d   = MemtoReg_in;
      alu_d   = ALU_result_in;
      rd_d    = Rd_in;
      rdata_d = (done & MemRead_in) ? mem_rdata : 32'h0;
    end

    mis_err_d = mis_err_q | mis_hit;
    to_err_d  = to_err_q | abort;
  end

  // State, memory interface and MEM/WB registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rdata_q   <= 32'h0;
      alu_q     <= 32'h0;
      rd_q      <= 5'h0;
      mis_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      rdata_q   <= rdata_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
      mis_err_q <= mis_err_d;
      to_err_q  <= to_err_d;
    end
  end

  // stall is combinational; gating with reset keeps it low while rst is held
  assign stall          = rst & stall_c;
  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign RegWrite_out   = rw_q;
  assign MemtoReg_out   = m2r_q;
  assign Read_data_out  = rdata_q;
  assign ALU_result_out = alu_q;
  assign Rd_out         = rd_q;
  assign misalign_err   = mis_err_q;
  assign timeout_err    = to_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4 so the abort path is short).
module tb_mem_access_stage;

  logic        clk, rst;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic [31:0] ALU_result_in, data_2_in;
  logic [4:0]  Rd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, RegWrite_out, MemtoReg_out, misalign_err, timeout_err;
  logic [31:0] Read_data_out, ALU_result_out;
  logic [4:0]  Rd_out;

  int checks = 0;
  int failures = 0;
  int stall_cnt;

  mem_access_stage #(.TIMEOUT(4), .CNT_W(3), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALU_result_in(ALU_result_in), .data_2_in(data_2_in), .Rd_in(Rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .Read_data_out(Read_data_out), .ALU_result_out(ALU_result_out),
    .Rd_out(Rd_out), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                       input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd);
    RegWrite_in   = rw;
    MemtoReg_in   = m2r;
    MemRead_in    = rd_en;
    MemWrite_in   = wr_en;
    ALU_result_in = alu;
    data_2_in     = d2;
    Rd_in         = rd;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #12;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rw", {31'h0, RegWrite_out}, 32'h0);
    chk("rst_err", {30'h0, misalign_err, timeout_err}, 32'h0);
    rst = 1'b1;
    step();

    // load 0x10, ack on first ACCESS cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    chk("ld_stall_idle", {31'h0, stall}, 32'h1);
    chk("ld_noreq_idle", {31'h0, mem_req}, 32'h0);
    step();
    chk("ld_req", {31'h0, mem_req}, 32'h1);
    chk("ld_we", {31'h0, mem_we}, 32'h0);
    chk("ld_addr", mem_addr, 32'h10);
    chk("ld_bubble", {31'h0, RegWrite_out}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", {31'h0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("ld_req_drop", {31'h0, mem_req}, 32'h0);
    chk("ld_rdata", Read_data_out, 32'hDEADBEEF);
    chk("ld_rw", {31'h0, RegWrite_out}, 32'h1);
    chk("ld_rd", {27'h0, Rd_out}, 32'd5);
    chk("ld_m2r", {31'h0, MemtoReg_out}, 32'h1);

    // store 0x20 <- 0x1234, ack after 3 wait cycles
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h1234, 5'd0);
    stall_cnt = 0;
    if (stall) stall_cnt++;
    for (int w = 0; w < 3; w++) begin
      step();
      if (stall) stall_cnt++;
      chk("st_req", {31'h0, mem_req}, 32'h1);
      chk("st_we", {31'h0, mem_we}, 32'h1);
      chk("st_addr", mem_addr, 32'h20);
      chk("st_wdata", mem_wdata, 32'h1234);
    end
    step();
    mem_ack = 1'b1;
    #1;
    if (stall) stall_cnt++;
    chk("st_addr_last", mem_addr, 32'h20);
    chk("st_stall_ack", {31'h0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("st_stall_cycles", stall_cnt, 32'd4);
    chk("st_req_drop", {31'h0, mem_req}, 32'h0);
    chk("st_rw", {31'h0, RegWrite_out}, 32'h0);

    // misaligned load 0x22
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd7);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    step();
    chk("mis_noreq", {31'h0, mem_req}, 32'h0);
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_rw", {31'h0, RegWrite_out}, 32'h0);
    chk("mis_rd", {27'h0, Rd_out}, 32'd7);

    // timeout: load 0x40, never acked
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3);
    stall_cnt = 0;
    for (int c = 0; c < 20 && stall; c++) begin
      stall_cnt++;
      step();
    end
    chk("to_stall_cycles", stall_cnt, 32'd4);
    chk("to_req_last", {31'h0, mem_req}, 32'h1);
    chk("to_err_before", {31'h0, timeout_err}, 32'h0);
    step();
    chk("to_req_drop", {31'h0, mem_req}, 32'h0);
    chk("to_err", {31'h0, timeout_err}, 32'h1);
    chk("to_bubble", {31'h0, RegWrite_out}, 32'h0);
    // late ack alongside an ALU op must be ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("late_stall", {31'h0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("late_req", {31'h0, mem_req}, 32'h0);
    chk("late_rw", {31'h0, RegWrite_out}, 32'h1);
    chk("late_rd", {27'h0, Rd_out}, 32'd9);
    chk("late_rdata", Read_data_out, 32'h0);
    chk("late_alu", ALU_result_out, 32'h55);

    // async reset during ACCESS wait
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hAA, 5'd0);
    step();
    chk("ar_req_pre", {31'h0, mem_req}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req", {31'h0, mem_req}, 32'h0);
    chk("ar_stall", {31'h0, stall}, 32'h0);
    chk("ar_err", {30'h0, misalign_err, timeout_err}, 32'h0);
    chk("ar_alu", ALU_result_out, 32'h0);
    chk("ar_rd", {27'h0, Rd_out}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd4);
    rst = 1'b1;
    step();
    chk("ar_add_rw", {31'h0, RegWrite_out}, 32'h1);
    chk("ar_add_alu", ALU_result_out, 32'h77);
    chk("ar_add_rd", {27'h0, Rd_out}, 32'd4);
    chk("ar_add_req", {31'h0, mem_req}, 32'h0);

    // ALU op, load, ALU op back-to-back
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 5'd1);
    chk("b2b_a1_stall", {31'h0, stall}, 32'h0);
    step();
    chk("b2b_a1_rd", {27'h0, Rd_out}, 32'd1);
    chk("b2b_a1_alu", ALU_result_out, 32'h100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd2);
    chk("b2b_ld_stall", {31'h0, stall}, 32'h1);
    step();
    chk("b2b_bubble", {31'h0, RegWrite_out}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    chk("b2b_ld_ack_stall", {31'h0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("b2b_ld_rd", {27'h0, Rd_out}, 32'd2);
    chk("b2b_ld_data", Read_data_out, 32'hCAFE);
    chk("b2b_ld_rw", {31'h0, RegWrite_out}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 5'd3);
    chk("b2b_a2_stall", {31'h0, stall}, 32'h0);
    step();
    chk("b2b_a2_rd", {27'h0, Rd_out}, 32'd3);
    chk("b2b_a2_alu", ALU_result_out, 32'h300);
    chk("b2b_a2_rdata", Read_data_out, 32'h0);
    chk("sticky_mis", {31'h0, misalign_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
